sd_block_responder: RTL and testbench

- Target (responder) side of the sd_lba / sd_rd / sd_wr / sd_ack 512-byte block-transfer handshake used by the save-state logic. It stands in for the HPS block device in simulation and in standalone builds.
- Services each block request against a local synchronous backing memory.
- Streams read data out on sd_buff_addr / sd_buff_dout / sd_buff_wr.
- Captures write data from sd_buff_din, which the initiator drives from a registered RAM with 1-cycle latency.

---
 rtl/sd_block_responder.sv | 164 ++++++++++++++++
 tb/tb_sd_block_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_block_responder.sv
// sd_block_responder: responder side of the sd_lba / sd_rd / sd_wr / sd_ack
// 512-byte block handshake, serviced against a local synchronous memory.
//
// Ports
//   clk_sys, RESET_n            clock, asynchronous active-low reset
//   sd_lba, sd_rd, sd_wr, wp     block request (levels) and write protect
//   sd_ack                       high for the whole transfer (513 cycles)
//   sd_buff_addr                 byte index within the block
//   sd_buff_dout, sd_buff_wr     read data and its 1-cycle strobe
//   sd_buff_din                  write data, valid 1 cycle after sd_buff_addr
//   mem_addr, mem_we, mem_din    backing memory port ({lba, byte})
//   mem_dout                     backing memory read data (1-cycle latency)
//   blk_done, blk_err            per-block completion / error pulses
//   blk_count                    completed block counter (wraps)
//
// sd_buff_dout and mem_din are muxes on top of the registered outputs of the
// two external RAMs. They are gated by their own registered strobes, so both
// read as zero outside a valid beat and during reset.
module sd_block_responder #(
    parameter int unsigned LBA_W      = 8,
    parameter int unsigned NUM_BLOCKS = 256,
    parameter int unsigned ACK_DELAY  = 4
) (
    input  logic               clk_sys,
    input  logic               RESET_n,
    input  logic [31:0]        sd_lba,
    input  logic               sd_rd,
    input  logic               sd_wr,
    input  logic               wp,
    output logic               sd_ack,
    output logic [8:0]         sd_buff_addr,
    output logic [7:0]         sd_buff_dout,
    output logic               sd_buff_wr,
    input  logic [7:0]         sd_buff_din,
    output logic [LBA_W+8:0]   mem_addr,
    output logic               mem_we,
    output logic [7:0]         mem_din,
    input  logic [7:0]         mem_dout,
    output logic               blk_done,
    output logic               blk_err,
    output logic [15:0]        blk_count
);

    localparam int unsigned SEEK_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
    localparam int unsigned CNT_W  = 10;
    localparam logic [CNT_W-1:0] LAST_BYTE = 10'd511;
    localparam logic [CNT_W-1:0] BYTE_END  = 10'd512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state;
    logic [SEEK_W-1:0]   seek_cnt;
    logic [CNT_W-1:0]    k;
    logic [LBA_W-1:0]    lba_q;
    logic                is_wr_q;
    logic                wp_q;
    logic                oor_q;

    // Read data is forced to 8'hFF for out-of-range blocks.
    assign sd_buff_dout = sd_buff_wr ? (oor_q ? 8'hFF : mem_dout) : 8'h00;
    assign mem_din      = mem_we ? sd_buff_din : 8'h00;

    // Transfer FSM with registered handshake and memory outputs.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= S_IDLE;
            seek_cnt     <= '0;
            k            <= '0;
            lba_q        <= '0;
            is_wr_q      <= 1'b0;
            wp_q         <= 1'b0;
            oor_q        <= 1'b0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            blk_done     <= 1'b0;
            blk_err      <= 1'b0;
            blk_count    <= '0;
        end else begin
            blk_done <= 1'b0;
            blk_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sd_rd | sd_wr) begin
                        lba_q    <= sd_lba[LBA_W-1:0];
                        is_wr_q  <= ~sd_rd;
                        wp_q     <= wp;
                        oor_q    <= (sd_lba >= 32'(NUM_BLOCKS));
                        seek_cnt <= '0;
                        state    <= S_SEEK;
                    end
                end
                S_SEEK: begin
                    if (seek_cnt == SEEK_W'(ACK_DELAY - 1)) begin
                        sd_ack <= 1'b1;
                        k      <= '0;
                        if (is_wr_q) begin
                            sd_buff_addr <= '0;
                            state        <= S_WRITE;
                        end else begin
                            // Byte 0 address goes out with ack so the first
                            // strobe lands one cycle later.
                            mem_addr <= {lba_q, 9'd0};
                            state    <= S_READ;
                        end
                    end else begin
                        seek_cnt <= seek_cnt + SEEK_W'(1);
                    end
                end
                S_READ: begin
                    // k counts memory addresses; the strobe trails it by one.
                    if (k == BYTE_END) begin
                        sd_buff_wr <= 1'b0;
                        sd_ack     <= 1'b0;
                        blk_done   <= 1'b1;
                        blk_err    <= oor_q;
                        blk_count  <= blk_count + 16'd1;
                        state      <= S_DONE;
                    end else begin
                        sd_buff_wr   <= 1'b1;
                        sd_buff_addr <= k[8:0];
                        if (k != LAST_BYTE) begin
                            mem_addr <= {lba_q, 9'(k + 10'd1)};
                        end
                        k <= k + 10'd1;
                    end
                end
                S_WRITE: begin
                    // k counts committed bytes; sd_buff_addr leads it by one.
                    if (k == BYTE_END) begin
                        mem_we    <= 1'b0;
                        sd_ack    <= 1'b0;
                        blk_done  <= 1'b1;
                        blk_err   <= oor_q | wp_q;
                        blk_count <= blk_count + 16'd1;
                        state     <= S_DONE;
                    end else begin
                        mem_we   <= ~(wp_q | oor_q);
                        mem_addr <= {lba_q, k[8:0]};
                        if (k != LAST_BYTE) begin
                            sd_buff_addr <= 9'(k + 10'd1);
                        end
                        k <= k + 10'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_responder.sv
// Testbench for sd_block_responder: backing memory and initiator RAM models,
// table of block transactions, plus mid-transfer reset and back-to-back runs.
module tb_sd_block_responder;

    localparam int unsigned LBA_W      = 8;
    localparam int unsigned NUM_BLOCKS = 256;
    localparam int unsigned ACK_DELAY  = 4;
    localparam int unsigned MEM_SIZE   = 1 << (LBA_W + 9);

    localparam int M_KX  = 0;  // k[7:0] ^ 8'h5A (preload pattern)
    localparam int M_FF  = 1;  // out of range
    localparam int M_INV = 2;  // ~k[7:0] (written from initiator RAM)

    logic              clk_sys = 1'b0;
    logic              RESET_n;
    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              wp;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din;
    logic [LBA_W+8:0]  mem_addr;
    logic              mem_we;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic              blk_done;
    logic              blk_err;
    logic [15:0]       blk_count;

    int checks   = 0;
    int failures = 0;
    logic [15:0] model_count;

    logic [7:0] mem      [0:MEM_SIZE-1];
    logic [7:0] init_ram [0:511];

    always #5 clk_sys = ~clk_sys;

    sd_block_responder #(
        .LBA_W      (LBA_W),
        .NUM_BLOCKS (NUM_BLOCKS),
        .ACK_DELAY  (ACK_DELAY)
    ) dut (
        .clk_sys      (clk_sys),
        .RESET_n      (RESET_n),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .wp           (wp),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .blk_done     (blk_done),
        .blk_err      (blk_err),
        .blk_count    (blk_count)
    );

    // Backing memory: registered read, read-before-write.
    always @(posedge clk_sys) begin
        mem_dout <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_din;
    end

    // Initiator RAM: registered read, data valid one cycle after address.
    always @(posedge clk_sys) begin
        sd_buff_din <= init_ram[sd_buff_addr];
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] lba;
        logic        wp;
        logic        exp_err;
        int          exp_we;
        int          exp_strobes;
        int          mode;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int mode, input int idx);
        logic [7:0] b;
        b = 8'(idx);
        case (mode)
            M_KX:    return b ^ 8'h5A;
            M_FF:    return 8'hFF;
            default: return ~b;
        endcase
    endfunction

    // One complete block transfer, checked cycle by cycle at the falling edge.
    task automatic run_block(input logic rd, input logic wr, input logic [31:0] lba,
                             input logic wpi, input logic exp_err, input int exp_we,
                             input int exp_strobes, input int mode, input string name);
        int   lat;
        int   ack_cyc;
        int   strobes;
        int   wes;
        int   bad;
        logic seen;
        repeat (2) @(negedge clk_sys);
        sd_rd  = rd;
        sd_wr  = wr;
        sd_lba = lba;
        wp     = wpi;
        lat = 0; seen = 1'b0; ack_cyc = 0; strobes = 0; wes = 0; bad = 0;
        while (!seen && lat < 50) begin
            @(negedge clk_sys);
            lat++;
            if (mem_we) bad++;
            if (sd_ack) seen = 1'b1;
        end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        // First sample after the accepting edge counts as 1.
        check({name, "_ack_latency"}, 32'(lat), 32'(ACK_DELAY + 1));
        if (!seen) return;
        do begin
            ack_cyc++;
            if (blk_done) bad++;
            if (sd_buff_wr) begin
                if (sd_buff_addr !== 9'(strobes) || sd_buff_dout !== exp_byte(mode, strobes)
                    || ack_cyc != strobes + 2) begin
                    if (bad == 0)
                        $display("  %s first bad strobe: addr=%0d dout=%0h cyc=%0d", name,
                                 sd_buff_addr, sd_buff_dout, ack_cyc);
                    bad++;
                end
                strobes++;
            end
            if (mem_we) begin
                if (mem_addr !== {lba[LBA_W-1:0], 9'(wes)} || mem_din !== ~8'(wes)
                    || ack_cyc != wes + 2)
                    bad++;
                wes++;
            end
            @(negedge clk_sys);
        end while (sd_ack && ack_cyc < 600);
        model_count = model_count + 16'd1;
        check({name, "_ack_cycles"}, 32'(ack_cyc), 32'd513);
        check({name, "_strobes"}, 32'(strobes), 32'(exp_strobes));
        check({name, "_mem_we"}, 32'(wes), 32'(exp_we));
        check({name, "_bad_beats"}, 32'(bad), 32'd0);
        check({name, "_blk_done"}, 32'(blk_done), 32'd1);
        check({name, "_blk_err"}, 32'(blk_err), 32'(exp_err));
        check({name, "_blk_count"}, 32'(blk_count), 32'(model_count));
        check({name, "_done_quiet"}, {30'd0, sd_buff_wr, mem_we}, 32'd0);
        @(negedge clk_sys);
        check({name, "_done_pulse"}, {30'd0, blk_done, blk_err}, 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        for (int i = 0; i < int'(MEM_SIZE); i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < 512; i++) init_ram[i] = ~8'(i);

        vecs[0]  = '{1'b1, 1'b0, 32'd3,   1'b0, 1'b0, 0,   512, M_KX};
        vecs[1]  = '{1'b0, 1'b1, 32'd7,   1'b0, 1'b0, 512, 0,   M_KX};
        vecs[2]  = '{1'b1, 1'b0, 32'd7,   1'b0, 1'b0, 0,   512, M_INV};
        vecs[3]  = '{1'b0, 1'b1, 32'd9,   1'b1, 1'b1, 0,   0,   M_KX};
        vecs[4]  = '{1'b1, 1'b0, 32'd9,   1'b0, 1'b0, 0,   512, M_KX};
        vecs[5]  = '{1'b1, 1'b0, 32'd300, 1'b0, 1'b1, 0,   512, M_FF};
        vecs[6]  = '{1'b0, 1'b1, 32'd300, 1'b0, 1'b1, 0,   0,   M_KX};
        vecs[7]  = '{1'b1, 1'b0, 32'd44,  1'b0, 1'b0, 0,   512, M_KX};
        vecs[8]  = '{1'b1, 1'b1, 32'd1,   1'b0, 1'b0, 0,   512, M_KX};
        vecs[9]  = '{1'b1, 1'b0, 32'd255, 1'b0, 1'b0, 0,   512, M_KX};
        vecs[10] = '{1'b1, 1'b0, 32'd256, 1'b0, 1'b1, 0,   512, M_FF};
        vecs[11] = '{1'b1, 1'b0, 32'd0,   1'b0, 1'b0, 0,   512, M_KX};
        vecs[12] = '{1'b1, 1'b0, 32'd3,   1'b1, 1'b0, 0,   512, M_KX};

        RESET_n = 1'b0;
        sd_lba  = '0;
        sd_rd   = 1'b0;
        sd_wr   = 1'b0;
        wp      = 1'b0;
        model_count = '0;
        repeat (3) @(negedge clk_sys);
        check("reset_outputs",
              {sd_ack, sd_buff_wr, mem_we, blk_done, blk_err, 27'd0},  32'd0);
        check("reset_count", 32'(blk_count), 32'd0);
        check("reset_addrs", {14'd0, sd_buff_addr, mem_addr}, 32'd0);
        RESET_n = 1'b1;

        foreach (vecs[i])
            run_block(vecs[i].rd, vecs[i].wr, vecs[i].lba, vecs[i].wp, vecs[i].exp_err,
                      vecs[i].exp_we, vecs[i].exp_strobes, vecs[i].mode,
                      $sformatf("vec%0d", i));

        // Reset in the middle of a read, at byte 200.
        repeat (2) @(negedge clk_sys);
        sd_rd = 1'b1; sd_lba = 32'd3;
        n = 0; seen = 1'b0;
        while (!seen && n < 700) begin
            @(negedge clk_sys);
            n++;
            if (sd_ack) sd_rd = 1'b0;
            if (sd_buff_wr && sd_buff_addr == 9'd200) seen = 1'b1;
        end
        sd_rd = 1'b0;
        check("midrst_reach_byte200", 32'(seen), 32'd1);
        #1 RESET_n = 1'b0;
        #1;
        check("midrst_ack", 32'(sd_ack), 32'd0);
        check("midrst_count", 32'(blk_count), 32'd0);
        check("midrst_strobes", {30'd0, sd_buff_wr, mem_we}, 32'd0);
        repeat (2) @(negedge clk_sys);
        RESET_n = 1'b1;
        model_count = '0;
        run_block(1'b1, 1'b0, 32'd3, 1'b0, 1'b0, 0, 512, M_KX, "after_rst");

        // Back-to-back sequential blocks from a fresh reset.
        @(negedge clk_sys);
        RESET_n = 1'b0;
        @(negedge clk_sys);
        RESET_n = 1'b1;
        model_count = '0;
        for (int i = 0; i < 64; i++)
            run_block(1'b1, 1'b0, 32'(100 + i), 1'b0, 1'b0, 0, 512, M_KX,
                      $sformatf("b2b%0d", i));
        check("b2b_total", 32'(blk_count), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
